// File: rtl/int_to_fp_pipe.sv
// Integer to IEEE-754 single/double converter, 3 register stages (out_valid 3 cycles after accept).
// Whole pipe stalls when out_valid & !out_ready; in_ready = !out_valid | out_ready.
module int_to_fp_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_data,
  input  logic             in_long,
  input  logic             in_unsigned,
  input  logic             in_dp,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic             out_nx,
  output logic             out_nv,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  logic advance;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance | rst;

  // S1: sign/magnitude of the (possibly extended) operand
  logic [63:0] data64, ext, mag_d;
  logic        neg_d;

  always_comb begin
    data64 = 64'(in_data);
    if ((XLEN == 64) && in_long)
      ext = data64;
    else if (in_unsigned)
      ext = {32'd0, data64[31:0]};
    else
      ext = {{32{data64[31]}}, data64[31:0]};
    neg_d = !in_unsigned && ext[63];
    mag_d = neg_d ? (~ext + 64'd1) : ext;
  end

  logic             s1_vld, s1_sign, s1_dp;
  logic [63:0]      s1_mag;
  logic [2:0]       s1_rm;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
    end else if (advance) begin
      s1_vld  <= in_valid;
      s1_sign <= neg_d;
      s1_mag  <= mag_d;
      s1_dp   <= in_dp;
      s1_rm   <= in_rm;
      s1_tag  <= in_tag;
    end
  end

  // S2: MSB position and left normalisation so the hidden 1 lands in bit 63
  logic [5:0]  msb_d;
  logic [63:0] norm_d;

  always_comb begin
    msb_d = '0;
    for (int i = 0; i < 64; i++)
      if (s1_mag[i]) msb_d = 6'(i);
    norm_d = s1_mag << (6'd63 - msb_d);
  end

  logic             s2_vld, s2_sign, s2_zero, s2_dp;
  logic [63:0]      s2_norm;
  logic [5:0]       s2_msb;
  logic [2:0]       s2_rm;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
    end else if (advance) begin
      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_zero <= ~|s1_mag;
      s2_norm <= norm_d;
      s2_msb  <= msb_d;
      s2_dp   <= s1_dp;
      s2_rm   <= s1_rm;
      s2_tag  <= s1_tag;
    end
  end

  // S3: round and pack
  logic        g, r, st, l, inc, carry, nv_d, nx_d;
  logic [2:0]  rm_eff;
  logic [51:0] frac;
  logic [52:0] frac_sum;
  logic [10:0] exp_w;
  logic [63:0] res_d;

  always_comb begin
    nv_d   = s2_rm > RM_RMM;
    rm_eff = nv_d ? RM_RNE : s2_rm;
    if (s2_dp) begin
      l    = s2_norm[11];
      g    = s2_norm[10];
      r    = s2_norm[9];
      st   = |s2_norm[8:0];
      frac = s2_norm[62:11];
    end else begin
      l    = s2_norm[40];
      g    = s2_norm[39];
      r    = s2_norm[38];
      st   = |s2_norm[37:0];
      frac = {29'd0, s2_norm[62:40]};
    end
    case (rm_eff)
      RM_RNE:  inc = g & (l | r | st);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s2_sign & (g | r | st);
      RM_RUP:  inc = !s2_sign & (g | r | st);
      RM_RMM:  inc = g;
      default: inc = 1'b0;
    endcase
    frac_sum = {1'b0, frac} + 53'(inc);
    // on a carry the fraction bits have already wrapped to zero
    carry    = s2_dp ? frac_sum[52] : frac_sum[23];
    exp_w    = (s2_dp ? 11'd1023 : 11'd127) + 11'(s2_msb) + 11'(carry);
    nx_d     = g | r | st;
    if (s2_zero) begin
      res_d = s2_dp ? 64'd0 : 64'hFFFF_FFFF_0000_0000;
      nx_d  = 1'b0;
    end else if (s2_dp) begin
      res_d = {s2_sign, exp_w, frac_sum[51:0]};
    end else begin
      res_d = {32'hFFFF_FFFF, s2_sign, exp_w[7:0], frac_sum[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_nx     <= 1'b0;
      out_nv     <= 1'b0;
      out_tag    <= '0;
    end else if (advance) begin
      out_valid <= s2_vld;
      if (s2_vld) begin
        out_result <= res_d;
        out_nx     <= nx_d;
        out_nv     <= nv_d;
        out_tag    <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Self-checking bench for int_to_fp_pipe: directed table, backpressure, reset flush, random vs model.
module tb_int_to_fp_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_long, in_unsigned, in_dp;
  logic [63:0] in_data;
  logic [2:0]  in_rm;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready, out_nx, out_nv;
  logic [63:0] out_result;
  logic [4:0]  out_tag;

  always #5 clk = ~clk;

  int_to_fp_pipe #(.XLEN(64), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_long(in_long), .in_unsigned(in_unsigned), .in_dp(in_dp),
    .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_nx(out_nx), .out_nv(out_nv), .out_tag(out_tag)
  );

  typedef struct {
    logic [63:0] data;
    bit          lng, uns, dp;
    bit [2:0]    rm;
    logic [63:0] res;
    bit          nx, nv;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    bit          nx, nv;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: exact integer value, then keep m+1 significant bits and round on the remainder.
  function automatic exp_t model(input logic [63:0] data, input bit lng, input bit uns,
                                 input bit dp, input bit [2:0] rm, input logic [4:0] tag);
    exp_t        e;
    longint      sv;
    bit          sign, up;
    logic [63:0] mag, kept, rem, half, frac;
    int          p, m, bias, sh;
    bit [2:0]    rme;
    if (lng)      sv = longint'(data);
    else if (uns) sv = longint'({32'd0, data[31:0]});
    else          sv = longint'(int'(data[31:0]));
    sign  = !uns && (sv < 0);
    mag   = 64'(sign ? -sv : sv);
    e.tag = tag;
    e.nv  = rm > 3'd4;
    rme   = e.nv ? 3'd0 : rm;
    m     = dp ? 52 : 23;
    bias  = dp ? 1023 : 127;
    if (mag == 0) begin
      e.res = dp ? 64'd0 : 64'hFFFF_FFFF_0000_0000;
      e.nx  = 1'b0;
      return e;
    end
    p = 63;
    while (!mag[p]) p--;
    up = 1'b0;
    rem = 64'd0;
    if (p <= m) begin
      kept = mag << (m - p);
    end else begin
      sh   = p - m;
      kept = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      case (rme)
        3'd0:    up = (rem > half) || (rem == half && kept[0]);
        3'd2:    up = sign && rem != 0;
        3'd3:    up = !sign && rem != 0;
        3'd4:    up = rem >= half;
        default: up = 1'b0;
      endcase
    end
    e.nx = rem != 0;
    kept = kept + 64'(up);
    if ((kept >> (m + 1)) != 0) begin
      p++;
      kept = kept >> 1;
    end
    frac = kept - (64'd1 << m);
    if (dp) e.res = {sign, 11'(bias + p), frac[51:0]};
    else    e.res = {32'hFFFF_FFFF, sign, 8'(bias + p), frac[22:0]};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic [63:0] d, input bit lng, input bit uns, input bit dp,
                        input bit [2:0] rm, input logic [4:0] tag);
    in_data = d; in_long = lng; in_unsigned = uns; in_dp = dp; in_rm = rm; in_tag = tag;
  endtask

  // Called just after a negedge once inputs are driven: retire a handshaken result, log an acceptance.
  task automatic step(input string name);
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s: unexpected result tag %0d", name, out_tag);
      end else begin
        e = sb.pop_front();
        chk({name, " result"}, out_result, e.res);
        chk({name, " nx/nv"}, {62'd0, out_nx, out_nv}, {62'd0, e.nx, e.nv});
        chk({name, " tag"}, 64'(out_tag), 64'(e.tag));
      end
    end
    if (in_valid && in_ready)
      sb.push_back(model(in_data, in_long, in_unsigned, in_dp, in_rm, in_tag));
  endtask

  // Called just after a negedge with an empty pipe and out_ready=1.
  task automatic run_vec(input vec_t v, input logic [4:0] tag, input string name);
    int n;
    set_op(v.data, v.lng, v.uns, v.dp, v.rm, tag);
    in_valid = 1'b1;
    #1 chk({name, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    forever begin
      #1;
      n++;
      if (out_valid || n >= 8) break;
      @(negedge clk);
    end
    chk({name, " latency"}, 64'(n), 64'd3);
    chk({name, " result"}, out_result, v.res);
    chk({name, " nx"}, 64'(out_nx), 64'(v.nx));
    chk({name, " nv"}, 64'(out_nv), 64'(v.nv));
    chk({name, " tag"}, 64'(out_tag), 64'(tag));
    @(negedge clk);
  endtask

  vec_t tbl[15];
  vec_t vd;

  initial begin
    int t, acc, seq;
    logic [63:0] d;

    tbl[0]  = '{64'h1, 0, 0, 0, 3'd0, 64'hFFFFFFFF3F800000, 0, 0};
    tbl[1]  = '{64'h01000001, 0, 0, 0, 3'd0, 64'hFFFFFFFF4B800000, 1, 0};
    tbl[2]  = '{64'h01000001, 0, 0, 0, 3'd3, 64'hFFFFFFFF4B800001, 1, 0};
    tbl[3]  = '{64'hFFFFFFFF, 0, 1, 0, 3'd0, 64'hFFFFFFFF4F800000, 1, 0};
    tbl[4]  = '{64'h12345678FFFFFFFF, 0, 0, 0, 3'd0, 64'hFFFFFFFFBF800000, 0, 0};
    tbl[5]  = '{64'h8000000000000000, 1, 0, 1, 3'd1, 64'hC3E0000000000000, 0, 0};
    tbl[6]  = '{64'hFFFFFFFFFFFFFFFF, 1, 1, 1, 3'd2, 64'h43EFFFFFFFFFFFFF, 1, 0};
    tbl[7]  = '{64'hFFFFFFFFFFFFFFFF, 1, 1, 1, 3'd5, 64'h43F0000000000000, 1, 1};
    tbl[8]  = '{64'h0, 0, 0, 0, 3'd3, 64'hFFFFFFFF00000000, 0, 0};
    tbl[9]  = '{64'h0, 1, 0, 1, 3'd2, 64'h0000000000000000, 0, 0};
    tbl[10] = '{64'h80000000, 0, 0, 0, 3'd0, 64'hFFFFFFFFCF000000, 0, 0};
    tbl[11] = '{64'h7FFFFFFF, 0, 0, 1, 3'd0, 64'h41DFFFFFFFC00000, 0, 0};
    tbl[12] = '{64'h01000005, 0, 1, 0, 3'd4, 64'hFFFFFFFF4B800003, 1, 0};
    tbl[13] = '{64'h01000005, 0, 1, 0, 3'd7, 64'hFFFFFFFF4B800002, 1, 1};
    tbl[14] = '{64'hFEFFFFFF, 0, 0, 0, 3'd2, 64'hFFFFFFFFCB800001, 1, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_op(64'd0, 0, 0, 0, 3'd0, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_result", out_result, 64'd0);
    chk("reset flags/tag", {55'd0, out_nx, out_nv, 2'b0, out_tag}, 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++)
      run_vec(tbl[i], 5'(i), $sformatf("vec%0d", i));

    // Backpressure: five back-to-back ops with the consumer stalled at first.
    acc = 0; t = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      in_valid  = (t < 5);
      d = {32'hFFFF_FFFF, 32'(t * 32'h0123_4567 + 1)};
      set_op(d, t[2], t[0], t[1], 3'(t % 5), 5'(t));
      step("bp");
      if (in_valid && in_ready) begin
        t++;
        if (cyc < 6) acc++;
      end
      if (cyc == 5) begin
        chk("bp accepts while stalled", 64'(acc), 64'd3);
        chk("bp in_ready while stalled", 64'(in_ready), 64'd0);
      end
    end
    in_valid = 1'b0;
    chk("bp all issued", 64'(t), 64'd5);
    chk("bp all retired", 64'(sb.size()), 64'd0);

    // Reset with two ops in flight and the output stalled.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    set_op(64'd100, 0, 0, 0, 3'd0, 5'd20);
    step("rst");
    @(negedge clk);
    set_op(64'd200, 0, 0, 1, 3'd0, 5'd21);
    step("rst");
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    step("rst");
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    set_op(64'd300, 0, 0, 0, 3'd0, 5'd22);
    #1 chk("in_ready during reset", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sb.delete();
    #1;
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush out_result", out_result, 64'd0);
    vd = '{64'hFFFFFFFB, 0, 0, 0, 3'd0, 64'hFFFFFFFFC0A00000, 0, 0};
    run_vec(vd, 5'd9, "post-reset");

    // Random traffic with random consumer stalls.
    seq = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0) && (seq < 600);
      case ($urandom_range(0, 5))
        0: d = 64'd0;
        1: d = {$urandom, $urandom};
        2: d = 64'd1 << $urandom_range(0, 63);
        3: d = '1;
        4: d = 64'($urandom_range(0, 255));
        default: d = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      if ($urandom_range(0, 1) == 1) d = -d;
      set_op(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 5'(seq));
      step("rnd");
      if (in_valid && in_ready) seq++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && sb.size() > 0; cyc++) begin
      @(negedge clk);
      step("drain");
    end
    chk("rnd drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_to_fp_pipe.md
INT_TO_FP_PIPE -- requirements
Module: int_to_fp_pipe

Interface
REQ-001 Parameter: XLEN, 64, maximum integer operand width; legal values 32 or 64.
REQ-002 Parameter: TAG_W, 5, width of the opaque tag carried alongside each operation.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  the operation on the in_* ports is offered.
REQ-006 Port: in_ready  output  1  the block accepts the operation this cycle.
REQ-007 Port: in_data  input  XLEN  integer operand.
REQ-008 Port: in_long  input  1  1 = 64-bit operand, 0 = use in_data[31:0]; ignored (treated 0) when XLEN=32.
REQ-009 Port: in_unsigned  input  1  1 = unsigned, 0 = two's-complement.
REQ-010 Port: in_dp  input  1  1 = double-precision result, 0 = single-precision.
REQ-011 Port: in_rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-012 Port: in_tag  input  TAG_W  tag returned unchanged with the result.
REQ-013 Port: out_valid  output  1  the result on the out_* ports is valid.
REQ-014 Port: out_ready  input  1  the consumer takes the result this cycle.
REQ-015 Port: out_result  output  64  IEEE-754 result; a single-precision result is NaN-boxed (bits [63:32] all ones).
REQ-016 Port: out_nx  output  1  inexact flag.
REQ-017 Port: out_nv  output  1  illegal rounding mode flag.
REQ-018 Port: out_tag  output  TAG_W  tag of the result.

Function
REQ-019 The datapath SHALL be three register stages:
  - S1 captures the operands, zero-extends or sign-extends a 32-bit operand, and forms the sign and magnitude;
  - S2 computes the leading-zero count and left-normalises the magnitude;
  - S3 rounds, packs the exponent and mantissa, and drives the out_* registers.
REQ-020 Pipeline advance SHALL be advance = !out_valid | out_ready.
  - in_ready = advance.
  - An operation is accepted when in_valid & in_ready.
REQ-021 On an accepted operation, out_valid SHALL assert exactly 3 cycles after acceptance, provided advance stays 1.
  - While advance=0, every stage SHALL hold its contents; no operation is dropped or duplicated.
REQ-022 Results SHALL leave the block in acceptance order.
  - Up to 3 operations SHALL be in flight at once.
  - A bubble (in_valid=0) SHALL propagate as an invalid stage.
REQ-023 Sign and magnitude: for a signed negative operand, sign=1 and magnitude = two's-complement negation.
  - -2^31 and -2^63 SHALL produce the correct magnitude, 2^31 and 2^63.
  - For an unsigned operand, sign=0.
REQ-024 Exponent and mantissa:
  - Biased exponent = bias + (W-1-lzc), where W is the operand width (32 or 64), and bias is 127 for single precision and 1023 for double precision.
  - The mantissa is the normalised magnitude below the hidden 1.
REQ-025 Rounding SHALL use guard, round and sticky bits taken from the normalised magnitude below the mantissa LSB.
  - RNE: increment when G & (L|R|S).
  - RTZ: never increment.
  - RDN: increment when sign & (G|R|S).
  - RUP: increment when !sign & (G|R|S).
  - RMM: increment when G.
REQ-026 A rounding carry out of the mantissa SHALL increment the exponent and clear the mantissa.
REQ-027 out_nx SHALL be G|R|S, independent of the rounding mode.
  - out_nx SHALL be 0 for any 32-bit operand converted to double precision.
REQ-028 An operand of zero SHALL produce +0 in every mode, with out_nx=0.
  - Single precision: 0xFFFFFFFF00000000.
  - Double precision: 0x0000000000000000.
REQ-029 in_rm of 101, 110 or 111 SHALL be converted as RNE with out_nv=1; for legal modes out_nv=0.
REQ-030 out_result, out_nx, out_nv and out_tag SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-031 When rst=1 at a clock edge:
  - all stage valid bits, and out_valid, SHALL be 0;
  - out_result, out_nx, out_nv and out_tag SHALL be 0;
  - in-flight operations SHALL be discarded.
REQ-032 During the rst=1 cycle, in_ready SHALL be 1, but no operation is accepted that cycle.
  - After reset, the first acceptance is possible in the first cycle with rst=0.

Verification
REQ-033 Signed 32-bit 1, single precision, RNE -> out_result 0xFFFFFFFF3F800000, out_nx=0, out_valid exactly 3 cycles after acceptance.
REQ-034 Signed 32-bit 0x01000001, single precision:
  - RNE -> 0xFFFFFFFF4B800000, out_nx=1;
  - RUP -> 0xFFFFFFFF4B800001, out_nx=1.
REQ-035 Rounding carry and sign handling:
  - unsigned 32-bit 0xFFFFFFFF, single precision, RNE -> 0xFFFFFFFF4F800000, out_nx=1;
  - the same operand signed (-1) -> 0xFFFFFFFFBF800000, out_nx=0.
REQ-036 Double-precision and illegal-mode cases:
  - signed 64-bit 0x8000000000000000, double precision, RTZ -> 0xC3E0000000000000, out_nx=0;
  - unsigned 64-bit 0xFFFFFFFFFFFFFFFF, double precision, RDN -> 0x43EFFFFFFFFFFFFF, out_nx=1;
  - the same operand with in_rm=101 -> 0x43F0000000000000, out_nv=1.
REQ-037 Backpressure: issue tags 0..4 back-to-back with out_ready=0.
  - in_ready SHALL drop after 3 acceptances.
  - Releasing out_ready SHALL return tags 0..4 in order with the correct results.
REQ-038 Reset mid-operation: assert rst for 1 cycle with 2 operations in flight.
  - out_valid SHALL stay 0 until a new operation completes 3 cycles after its acceptance.
